// File: rtl/hub75_pkg.sv
// ============================================================================
// Module  : hub75_pkg
// Brief   : Shared panel geometry defaults and framebuffer-writer FSM encoding.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package hub75_pkg;

    localparam int DEF_BITS_PER_PIXEL = 24;
    localparam int DEF_PANEL_WIDTH    = 64;
    localparam int DEF_PANEL_HEIGHT   = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_PRIME = 2'b01,
        ST_RUN   = 2'b10
    } fb_state_t;

endpackage : hub75_pkg

`default_nettype wire

// File: rtl/fb_writer_if.sv
// ============================================================================
// Module  : fb_writer_if
// Brief   : SPI pixel input side and framebuffer write side of fb_writer.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface fb_writer_if
    import hub75_pkg::*;
#(
    parameter int BITS_PER_PIXEL = DEF_BITS_PER_PIXEL,
    parameter int ADDR_BITS      = $clog2(DEF_PANEL_WIDTH * DEF_PANEL_HEIGHT)
);

    logic                      spi_cs_n;
    logic                      pixel_clk;
    logic [BITS_PER_PIXEL-1:0] pixel_data;

    logic                      write_en;
    logic [ADDR_BITS:0]        write_addr;
    logic [BITS_PER_PIXEL-1:0] write_data;
    logic                      fb_bank;
    logic                      frame_done;
    logic                      short_frame;

    // master: the writer, which owns the framebuffer write port
    modport master (
        input  spi_cs_n, pixel_clk, pixel_data,
        output write_en, write_addr, write_data, fb_bank, frame_done, short_frame
    );

    modport slave (
        output spi_cs_n, pixel_clk, pixel_data,
        input  write_en, write_addr, write_data, fb_bank, frame_done, short_frame
    );

endinterface : fb_writer_if

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module  : sync_2ff
// Brief   : Two-flop synchroniser for a single asynchronous bit.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_2ff
    import hub75_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff

`default_nettype wire

// File: rtl/fb_writer.sv
// ============================================================================
// Module  : fb_writer
// Brief   : Writes SPI-delivered pixels into the hidden bank of a double
//           buffered framebuffer and flips banks after each full frame.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module fb_writer
    import hub75_pkg::*;
#(
    parameter int BITS_PER_PIXEL = DEF_BITS_PER_PIXEL,
    parameter int PANEL_WIDTH    = DEF_PANEL_WIDTH,
    parameter int PANEL_HEIGHT   = DEF_PANEL_HEIGHT
) (
    input  wire logic   clk,
    input  wire logic   reset,
    fb_writer_if.master bus
);

    localparam int ADDR_BITS = $clog2(PANEL_WIDTH * PANEL_HEIGHT);
    localparam logic [ADDR_BITS-1:0] c_LAST_IDX = ADDR_BITS'(PANEL_WIDTH * PANEL_HEIGHT - 1);
    localparam logic [ADDR_BITS-1:0] c_ONE      = ADDR_BITS'(1);

    logic w_cs_n_sync;
    logic w_pclk_sync;
    logic w_pix_evt;
    logic w_do_write;
    logic w_abort;
    logic w_short;

    fb_state_t r_state;
    fb_state_t w_state_next;

    logic                      r_pclk_prev;
    logic [ADDR_BITS-1:0]      r_idx;
    logic                      r_bank;
    logic                      r_write_en;
    logic [ADDR_BITS:0]        r_waddr;
    logic [BITS_PER_PIXEL-1:0] r_wdata;
    logic                      r_frame_done;
    logic                      r_short;

    // chip select idles high, pixel strobe idles low
    sync_2ff #(.RESET_VAL(1'b1)) u_sync_cs (
        .clk (clk),
        .rst (reset),
        .i_d (bus.spi_cs_n),
        .o_q (w_cs_n_sync)
    );

    sync_2ff #(.RESET_VAL(1'b0)) u_sync_pclk (
        .clk (clk),
        .rst (reset),
        .i_d (bus.pixel_clk),
        .o_q (w_pclk_sync)
    );

    assign w_pix_evt = w_pclk_sync & ~r_pclk_prev;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // chip-select release is checked first so it wins over a coincident pixel
    always_comb begin
        w_state_next = r_state;
        w_do_write   = 1'b0;
        w_abort      = 1'b0;
        w_short      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_cs_n_sync) begin
                    w_state_next = ST_PRIME;
                end
            end
            ST_PRIME: begin
                if (w_cs_n_sync) begin
                    w_state_next = ST_IDLE;
                    w_abort      = 1'b1;
                end else if (w_pix_evt) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_cs_n_sync) begin
                    w_state_next = ST_IDLE;
                    w_abort      = 1'b1;
                    w_short      = (r_idx != '0);
                end else if (w_pix_evt) begin
                    w_do_write = 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pclk_prev  <= 1'b0;
            r_idx        <= '0;
            r_bank       <= 1'b0;
            r_write_en   <= 1'b0;
            r_waddr      <= '0;
            r_wdata      <= '0;
            r_frame_done <= 1'b0;
            r_short      <= 1'b0;
        end else begin
            r_pclk_prev  <= w_pclk_sync;
            r_write_en   <= w_do_write;
            r_frame_done <= w_do_write && (r_idx == c_LAST_IDX);
            r_short      <= w_short;
            // bank flips the cycle after the last write of a frame is presented
            r_bank       <= r_bank ^ r_frame_done;

            if (w_pix_evt) begin
                r_wdata <= bus.pixel_data;
            end

            if (w_do_write) begin
                r_waddr <= {~r_bank, r_idx};
            end

            if (w_abort) begin
                r_idx <= '0;
            end else if (w_do_write) begin
                r_idx <= (r_idx == c_LAST_IDX) ? '0 : r_idx + c_ONE;
            end
        end
    end

    assign bus.write_en    = r_write_en;
    assign bus.write_addr  = r_waddr;
    assign bus.write_data  = r_wdata;
    assign bus.fb_bank     = r_bank;
    assign bus.frame_done  = r_frame_done;
    assign bus.short_frame = r_short;

endmodule : fb_writer

`default_nettype wire
